// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store to RAM port B; rsp after load 2+RAM_LATENCY, store 2, error 1 cycle.
// No rsp backpressure (req_ready only in IDLE); define MMIO_LED_EN for the led_out MMIO register.
module mem_access_unit #(
  parameter int unsigned DMEM_WORDS  = 256,
  parameter int unsigned RAM_LATENCY = 1,
  parameter logic [31:0] MMIO_ADDR   = 32'h0000_01FC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_web,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
`ifdef MMIO_LED_EN
  ,
  output logic [15:0] led_out
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int unsigned LAT_W = $clog2(RAM_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RAM_LATENCY - 1);
  localparam logic [32:0] DMEM_BYTES = 33'(DMEM_WORDS) << 2;
`ifdef MMIO_LED_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  state_t           r_state, w_state_nxt;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [3:0]       r_mask;
  logic             r_mmio;
  logic [LAT_W-1:0] r_lat_cnt;

  logic        w_req_mmio, w_chk_fail;
  logic [3:0]  w_mask;
  logic [31:0] w_din, w_word, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Request checks, evaluated on the unregistered request at accept time
  assign w_req_mmio = MMIO_EN && (req_addr == MMIO_ADDR);
  assign w_chk_fail = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11)
                    || (req_we && req_funct3[2])
                    || ((req_funct3[1:0] == 2'b01) && req_addr[0])
                    || ((req_funct3 == 3'd2) && (req_addr[1:0] != 2'b00))
                    || (({1'b0, req_addr} >= DMEM_BYTES) && !w_req_mmio);

  always_comb begin
    w_mask = 4'b1111;
    w_din  = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_mask = 4'b0001 << req_addr[1:0];
        w_din  = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_mask = 4'b0011 << req_addr[1:0];
        w_din  = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MMIO_LED_EN
  logic [15:0] r_led;
  assign led_out = r_led;
  assign w_word  = r_mmio ? {16'h0000, r_led} : ram_dout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led <= 16'h0000;
    end else if (r_state == S_ISSUE && r_we && r_mmio) begin
      if (r_mask[0]) r_led[7:0]  <= ram_din[7:0];
      if (r_mask[1]) r_led[15:8] <= ram_din[15:8];
    end
  end
`else
  assign w_word = ram_dout;
`endif

  always_comb begin
    w_load = 32'h0;
    w_half = ram_addr[1] ? w_word[31:16] : w_word[15:0];
    case (ram_addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    case (r_funct3)
      3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd2:    w_load = w_word;
      3'd4:    w_load = {24'h0, w_byte};
      3'd5:    w_load = {16'h0, w_half};
      default: w_load = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // web is decoded from state so reset clears it without waiting for a clock
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    ram_web     = 4'b0000;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_chk_fail ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (r_we) begin
          if (!r_mmio) ram_web = r_mask;
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_lat_cnt == LAT_LAST) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we      <= 1'b0;
      r_funct3  <= 3'd0;
      r_mask    <= 4'b0000;
      r_mmio    <= 1'b0;
      r_lat_cnt <= '0;
      ram_addr  <= 32'h0;
      ram_din   <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_mask    <= w_mask;
            r_mmio    <= w_req_mmio;
            r_lat_cnt <= '0;
            if (w_chk_fail) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              ram_addr <= req_addr;
              if (req_we) ram_din <= w_din;
            end
          end
        end
        S_ISSUE: begin
          if (r_we) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
          end
        end
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          if (r_lat_cnt == LAT_LAST) begin
            rsp_rdata <= w_load;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
